// File: rtl/iw_collect_n.sv
// rtl/iw_collect_n.sv - collects N_OPS operand words into a vector and launches it to the IMC core
// Optional feature macro: IW_DOUBLE_BUF_EN (two ping-pong collection banks)
module iw_collect_n #(
  parameter int DATA_W = 16,
  parameter int N_OPS  = 4,
  parameter int CNT_W  = $clog2(N_OPS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dataReady,
  input  logic [DATA_W-1:0]       dataIn,
  output logic                    dataAccept,
  input  logic                    flush,
  input  logic                    imc_ready,
  output logic                    imc_start,
  output logic [N_OPS*DATA_W-1:0] ops,
  output logic [CNT_W-1:0]        fill_level
);

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_OPS - 1);
  localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(N_OPS);

  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_inc_d;
  logic [N_OPS*DATA_W-1:0] ops_q;
  logic                    imc_start_q;
  logic                    take_d;

  assign cnt_inc_d = cnt_q + CNT_W'(1);
  assign take_d    = dataReady && dataAccept;
  assign ops       = ops_q;
  assign imc_start = imc_start_q;

`ifdef IW_DOUBLE_BUF_EN

  logic [1:0][N_OPS*DATA_W-1:0] bank_q;
  logic [1:0]                   full_q;
  logic                         wr_sel_q;
  logic                         rd_sel_q;
  logic                         launch_d;

  // Collection stalls only when both banks hold un-launched sets
  assign dataAccept = ~(&full_q);
  assign fill_level = (&full_q) ? FULL_LVL : cnt_q;
  assign launch_d   = full_q[rd_sel_q] && imc_ready;

  // Ping-pong banks: launch drains the oldest full bank while the other keeps filling
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q      <= '0;
      full_q      <= '0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      cnt_q       <= '0;
      ops_q       <= '0;
      imc_start_q <= 1'b0;
    end else begin
      imc_start_q <= 1'b0;
      if (flush) begin
        full_q   <= '0;
        wr_sel_q <= 1'b0;
        rd_sel_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        // Launch and fill never touch the same bank: the write bank is never full when accepting
        if (launch_d) begin
          ops_q            <= bank_q[rd_sel_q];
          imc_start_q      <= 1'b1;
          full_q[rd_sel_q] <= 1'b0;
          rd_sel_q         <= ~rd_sel_q;
        end
        if (take_d) begin
          for (int i = 0; i < N_OPS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
              bank_q[wr_sel_q][i*DATA_W +: DATA_W] <= dataIn;
            end
          end
          if (cnt_q == LAST_SLOT) begin
            full_q[wr_sel_q] <= 1'b1;
            wr_sel_q         <= ~wr_sel_q;
            cnt_q            <= '0;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
      end
    end
  end

`else

  typedef enum logic {
    S_COLLECT,
    S_FULL
  } state_t;

  state_t                  state_q;
  logic [N_OPS*DATA_W-1:0] bank_q;

  // Single bank: no collection while a complete set waits for the core
  assign dataAccept = (state_q == S_COLLECT);
  assign fill_level = (state_q == S_FULL) ? FULL_LVL : cnt_q;

  // Collect/launch FSM with the one-cycle FULL bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_COLLECT;
      bank_q      <= '0;
      cnt_q       <= '0;
      ops_q       <= '0;
      imc_start_q <= 1'b0;
    end else begin
      imc_start_q <= 1'b0;
      if (flush) begin
        state_q <= S_COLLECT;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_COLLECT: begin
            if (dataReady) begin
              for (int i = 0; i < N_OPS; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                  bank_q[i*DATA_W +: DATA_W] <= dataIn;
                end
              end
              if (cnt_q == LAST_SLOT) begin
                state_q <= S_FULL;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_inc_d;
              end
            end
          end
          S_FULL: begin
            if (imc_ready) begin
              ops_q       <= bank_q;
              imc_start_q <= 1'b1;
              state_q     <= S_COLLECT;
            end
          end
          default: state_q <= S_COLLECT;
        endcase
      end
    end
  end

  // take_d is only meaningful for the banked build; keep it observed here
  logic unused_take;
  assign unused_take = take_d;

`endif

endmodule

// File: tb/tb_iw_collect_n.sv
// tb/tb_iw_collect_n.sv - randomized and directed bench for iw_collect_n against a queue-based model
module tb_iw_collect_n;

  localparam int DW = 16;
  localparam int N  = 4;
`ifdef IW_DOUBLE_BUF_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst, dataReady, flush, imc_ready;
  logic [DW-1:0] dataIn;
  logic          dataAccept, imc_start;
  logic [N*DW-1:0] ops;
  logic [2:0]    fill_level;

  logic          rst2, rdy2, flush2, ir2;
  logic [7:0]    din2;
  logic          acc2, start2;
  logic [23:0]   ops2;
  logic [1:0]    fill2;

  always #5 clk = ~clk;

  iw_collect_n #(.DATA_W(DW), .N_OPS(N)) dut (
    .clk(clk), .rst(rst), .dataReady(dataReady), .dataIn(dataIn),
    .dataAccept(dataAccept), .flush(flush), .imc_ready(imc_ready),
    .imc_start(imc_start), .ops(ops), .fill_level(fill_level)
  );

  iw_collect_n #(.DATA_W(8), .N_OPS(3)) dut2 (
    .clk(clk), .rst(rst2), .dataReady(rdy2), .dataIn(din2),
    .dataAccept(acc2), .flush(flush2), .imc_ready(ir2),
    .imc_start(start2), .ops(ops2), .fill_level(fill2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: words of the set being collected, and complete sets awaiting launch
  logic [DW-1:0]   coll[$];
  logic [N*DW-1:0] pend[$];
  logic [N*DW-1:0] m_ops;
  logic            m_start;
  logic            m_took;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_edge();
    logic acc;
    logic [N*DW-1:0] v;
    m_took = 1'b0;
    if (rst) begin
      coll.delete(); pend.delete(); m_start = 1'b0; m_ops = '0;
    end else if (flush) begin
      coll.delete(); pend.delete(); m_start = 1'b0;
    end else begin
      acc = (pend.size() < CAP);
      m_start = (pend.size() > 0) && imc_ready;
      if (m_start) m_ops = pend.pop_front();
      if (dataReady && acc) begin
        m_took = 1'b1;
        coll.push_back(dataIn);
        if (coll.size() == N) begin
          v = '0;
          for (int i = 0; i < N; i++) v[i*DW +: DW] = coll[i];
          pend.push_back(v);
          coll.delete();
        end
      end
    end
  endtask

  task automatic compare_all();
    int lvl;
    lvl = (pend.size() == CAP) ? N : coll.size();
    check_eq("accept", 64'(dataAccept), 64'(pend.size() < CAP));
    check_eq("fill_level", 64'(fill_level), 64'(lvl));
    check_eq("imc_start", 64'(imc_start), 64'(m_start));
    check_eq("ops", 64'(ops), 64'(m_ops));
  endtask

  task automatic cycle(input logic rdy, input logic [DW-1:0] din, input logic fl,
                       input logic ir, input logic rs);
    dataReady = rdy; dataIn = din; flush = fl; imc_ready = ir; rst = rs;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  logic          hold_v;
  logic [DW-1:0] hold_w;

  initial begin
    rst = 1'b1; dataReady = 1'b0; dataIn = '0; flush = 1'b0; imc_ready = 1'b0;
    rst2 = 1'b1; rdy2 = 1'b0; din2 = '0; flush2 = 1'b0; ir2 = 1'b0;
    m_ops = '0; m_start = 1'b0; m_took = 1'b0;
    @(negedge clk);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    check_eq("reset_ops", 64'(ops), 64'h0);
    check_eq("reset_accept", 64'(dataAccept), 64'h1);
    check_eq("reset_fill", 64'(fill_level), 64'h0);

    // Four words with core ready: launch one cycle after last capture
    cycle(1, 16'h0011, 0, 1, 0);
    cycle(1, 16'h0022, 0, 1, 0);
    cycle(1, 16'h0033, 0, 1, 0);
    cycle(1, 16'h0044, 0, 1, 0);
    check_eq("t1_no_early_start", 64'(imc_start), 64'h0);
    cycle(0, 0, 0, 1, 0);
    check_eq("t1_start", 64'(imc_start), 64'h1);
    check_eq("t1_ops", 64'(ops), 64'h0044_0033_0022_0011);
    cycle(0, 0, 0, 1, 0);
    check_eq("t1_pulse_one_cycle", 64'(imc_start), 64'h0);

    // Core busy while a full set waits, then a fifth word is offered
    cycle(1, 16'h1111, 0, 0, 0);
    cycle(1, 16'h2222, 0, 0, 0);
    cycle(1, 16'h3333, 0, 0, 0);
    cycle(1, 16'h4444, 0, 0, 0);
    cycle(1, 16'h5555, 0, 0, 0);
    cycle(1, 16'h5555, 0, 0, 0);
`ifndef IW_DOUBLE_BUF_EN
    check_eq("t2_stall_accept", 64'(dataAccept), 64'h0);
    check_eq("t2_stall_fill", 64'(fill_level), 64'h4);
    check_eq("t2_no_start", 64'(imc_start), 64'h0);
`endif
    cycle(1, 16'h5555, 0, 1, 0);
    check_eq("t2_start", 64'(imc_start), 64'h1);
    check_eq("t2_ops", 64'(ops), 64'h4444_3333_2222_1111);
`ifndef IW_DOUBLE_BUF_EN
    cycle(1, 16'h5555, 0, 0, 0);
    check_eq("t2_fifth_taken", 64'(fill_level), 64'h1);
`endif

    // Flush discards partial words; ops held across it
    cycle(1, 16'h0E01, 0, 0, 0);
    cycle(1, 16'h0E02, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    check_eq("t3_ops_held", 64'(ops), 64'h4444_3333_2222_1111);
    check_eq("t3_fill_cleared", 64'(fill_level), 64'h0);
    cycle(1, 16'h000A, 0, 1, 0);
    cycle(1, 16'h000B, 0, 1, 0);
    cycle(1, 16'h000C, 0, 1, 0);
    cycle(1, 16'h000D, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    check_eq("t3_ops", 64'(ops), 64'h000D_000C_000B_000A);

    // Reset mid-collection
    cycle(1, 16'h0F01, 0, 0, 0);
    cycle(1, 16'h0F02, 0, 0, 0);
    cycle(1, 16'h0F03, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    check_eq("t4_ops_reset", 64'(ops), 64'h0);
    check_eq("t4_fill_reset", 64'(fill_level), 64'h0);
    check_eq("t4_accept_reset", 64'(dataAccept), 64'h1);
    cycle(1, 16'h0101, 0, 1, 0);
    cycle(1, 16'h0202, 0, 1, 0);
    cycle(1, 16'h0303, 0, 1, 0);
    cycle(1, 16'h0404, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    check_eq("t4_start", 64'(imc_start), 64'h1);
    check_eq("t4_ops", 64'(ops), 64'h0404_0303_0202_0101);

    // Narrow instance: 3 x 8-bit operands
    cycle(0, 0, 0, 0, 0);
    check_eq("n3_reset_accept", 64'(acc2), 64'h1);
    check_eq("n3_reset_ops", 64'(ops2), 64'h0);
    rst2 = 1'b0; rdy2 = 1'b1; ir2 = 1'b1; din2 = 8'h01;
    cycle(0, 0, 0, 0, 0);
    din2 = 8'h02;
    cycle(0, 0, 0, 0, 0);
    din2 = 8'h03;
    cycle(0, 0, 0, 0, 0);
    rdy2 = 1'b0;
    check_eq("n3_no_early_start", 64'(start2), 64'h0);
    cycle(0, 0, 0, 0, 0);
    check_eq("n3_start", 64'(start2), 64'h1);
    check_eq("n3_ops", 64'(ops2), 64'h030201);

    // Randomized traffic; producer holds each word until it is accepted
    hold_v = 1'b0; hold_w = '0;
    for (int c = 0; c < 2000; c++) begin
      if (!hold_v && ($urandom % 10 < 7)) begin
        hold_v = 1'b1;
        hold_w = 16'($urandom);
      end
      cycle(hold_v, hold_w, ($urandom % 40) == 0, 1'($urandom % 2), ($urandom % 150) == 0);
      if (m_took) hold_v = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/iw_collect_n.md
# iw_collect_n

Parametrised input wrapper that sits between a word-serial producer and the IMC compute core. It collects `N_OPS` operands of `DATA_W` bits each through a `dataReady`/`dataAccept` handshake and packs them into one operand vector. When the vector is complete and the core signals `imc_ready`, it launches the vector with a one-cycle `imc_start` pulse. It generalises the fixed four-by-16-bit wrapper: width, operand count, partial-set flush and optional ping-pong collection banks are all configurable.

## Interface
Parameters:
- `DATA_W`, 16: width of each operand word.
- `N_OPS`, 4: operands per set, ≥ 2.
- `CNT_W`, `$clog2(N_OPS+1)`: width of `fill_level`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `dataReady`  in  1  producer has a valid word on `dataIn`.
- `dataIn`  in  DATA_W  operand word.
- `dataAccept`  out  1  wrapper can take a word this cycle (combinational from state).
- `flush`  in  1  synchronous discard of collected, not-yet-launched words.
- `imc_ready`  in  1  IMC core can start a new operation.
- `imc_start`  out  1  one-cycle launch pulse (registered).
- `ops`  out  N_OPS*DATA_W  launched operand vector; operand 0 in bits `[DATA_W-1:0]`, operand i in `[i*DATA_W +: DATA_W]`.
- `fill_level`  out  CNT_W  words held in the active collection bank.

## Operation
- A transfer occurs on a rising edge where `dataReady && dataAccept`. The word is written to slot `cnt` of the active bank, and `cnt` increments.
- `dataReady` without `dataAccept` transfers nothing. The producer holds the word until it is accepted.
- FSM for a single bank:
  - COLLECT: `dataAccept=1`. A transfer into slot `N_OPS-1` moves the FSM to FULL and sets `cnt=0`.
  - FULL: `dataAccept=0`. When `imc_ready=1` on an edge: `ops <=` bank contents, `imc_start <= 1`, and the FSM returns to COLLECT.
- `imc_start` is high for exactly one cycle per launch. `ops` changes only on the edge that raises `imc_start` and is otherwise held stable, including during flush.
- `imc_ready` low in FULL: the wrapper waits indefinitely, and no data is lost or overwritten.
- `flush=1` on an edge: `cnt=0`, every un-launched bank is discarded, and the FSM goes to COLLECT. `ops` and `imc_start` are unaffected, except that no launch occurs on that edge.
- Priority on the same edge: `rst` > `flush` > launch/transfer.
- `fill_level` equals `cnt`. In FULL with a single bank it reads `N_OPS`.
- Reset values: FSM=COLLECT, `cnt=0`, `ops=0`, `imc_start=0`, `fill_level=0`, `dataAccept=1` once `rst` is deasserted.

## Timing
- A transfer is a one-edge operation: one word per cycle when `dataReady` is held high.
- Last word captured on edge k with `imc_ready=1`: `imc_start` is high during cycle k+1 (set on edge k+1), and `ops` is valid from the same edge.
- Single bank: minimum period per set is `N_OPS+1` cycles, because of the FULL bubble.
- `imc_ready` is sampled only in FULL (or with a pending bank). A high `imc_ready` with no full set does nothing.
- Reset mid-collection discards partial words on the next edge. Any pending launch is dropped.

## Configuration
- `IW_DOUBLE_BUF_EN` defined: two collection banks in ping-pong.
  - When bank A fills, collection continues into bank B in the same cycle, and `dataAccept` stays high.
  - A launch copies the oldest full bank.
  - `dataAccept=0` only when both banks are full.
  - Simultaneous launch and last-word fill on the same edge: both take effect, and the just-filled bank becomes pending.
  - Sustained throughput is one set per `N_OPS` cycles while `imc_ready` stays high.
  - `fill_level` reports the bank currently collecting.
- `IW_DOUBLE_BUF_EN` not defined: single bank with the FULL-state bubble, as described above.

## Test plan
- Reset then four single-cycle words `0x0011`, `0x0022`, `0x0033`, `0x0044` (`N_OPS=4`, `DATA_W=16`, `imc_ready=1`) -> one `imc_start` pulse one cycle after the last capture, `ops=0x0044_0033_0022_0011`.
- `imc_ready=0` while 4 words are sent, then a fifth word is offered -> `dataAccept=0`, `fill_level=4`, no `imc_start`. Raise `imc_ready` -> launch next edge, then the fifth word is accepted.
- Two words sent, then `flush` pulsed, then 4 words `0xA..0xD` -> `ops=0x000D_000C_000B_000A`. The flushed words never appear and the prior `ops` is held through the flush.
- `rst` asserted after 3 words -> all outputs return to reset values, and the next 4 words form a clean set.
- With `IW_DOUBLE_BUF_EN`, 8 back-to-back words and `imc_ready=1` -> `dataAccept` is never low, and two `imc_start` pulses occur 4 cycles apart with the correct `ops` each time.
- With `DATA_W=8`, `N_OPS=3`, words `0x01`, `0x02`, `0x03` -> `ops=0x030201`.
